// File: rtl/param_expr_decoder.sv
// Inverse of the affine encoder y = x*MULTIPLIER + OFFSET: recovers quotient and
// remainder with a bit-serial restoring divider behind valid/ready handshakes.
module param_expr_decoder #(
  parameter int WIDTH      = 8,
  parameter int BASE       = 10,
  parameter int MULTIPLIER = 2,
  parameter int OFFSET     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_underflow,
  output logic             out_exact,
  output logic             out_is_result
);

  localparam int RESULT = BASE * MULTIPLIER + OFFSET;
  // RESULT outside the y range can never match, so is_result is tied low then
  localparam bit RES_FITS = (RESULT >= 0) && (longint'(RESULT) < (longint'(1) << WIDTH));
  localparam logic [WIDTH-1:0] RES_W   = WIDTH'(RESULT);
  localparam logic [WIDTH:0]   DIVISOR = (WIDTH+1)'(MULTIPLIER);
  localparam logic [WIDTH:0]   OFF_X   = (WIDTH+1)'(OFFSET);
  localparam int CW = $clog2(WIDTH + 1);

  if (MULTIPLIER < 1 || longint'(MULTIPLIER) >= (longint'(1) << WIDTH)) begin : g_bad_mult
    $error("param_expr_decoder: MULTIPLIER out of range");
  end
  if (OFFSET < 0 || longint'(OFFSET) >= (longint'(1) << WIDTH)) begin : g_bad_off
    $error("param_expr_decoder: OFFSET out of range");
  end

  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;
  state_t state, nxt;

  logic [WIDTH-1:0] y_q, quo;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             last, uf_q, isr_q;

  logic [WIDTH:0] diff, partial, sub_res;
  logic           qbit;

  assign diff    = {1'b0, y_q} - OFF_X;
  // quo doubles as the dividend shift register: its MSB feeds the next step
  assign partial = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign qbit    = (partial >= DIVISOR);
  assign sub_res = partial - DIVISOR;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = SUB;
      SUB:     nxt = DIV;
      DIV:     if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q           <= '0;
      quo           <= '0;
      rem           <= '0;
      cnt           <= '0;
      last          <= 1'b0;
      uf_q          <= 1'b0;
      isr_q         <= 1'b0;
      out_x         <= '0;
      out_rem       <= '0;
      out_underflow <= 1'b0;
      out_exact     <= 1'b0;
      out_is_result <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) y_q <= in_y;
        SUB: begin
          uf_q  <= diff[WIDTH];
          quo   <= diff[WIDTH] ? '0 : diff[WIDTH-1:0];
          isr_q <= RES_FITS && (y_q == RES_W);
          rem   <= '0;
          cnt   <= CW'(WIDTH - 1);
          last  <= 1'b0;
        end
        DIV: begin
          if (!last) begin
            quo <= (quo << 1) | WIDTH'(qbit);
            rem <= qbit ? sub_res : partial;
            if (cnt == '0) last <= 1'b1;
            else           cnt  <= cnt - 1'b1;
          end else begin
            // final DIV cycle publishes the result registers
            out_x         <= quo;
            out_rem       <= rem[WIDTH-1:0];
            out_underflow <= uf_q;
            out_exact     <= (rem == '0) && !uf_q;
            out_is_result <= isr_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_expr_decoder.sv
// Directed-vector bench: one decoder with MULTIPLIER=3/OFFSET=5/BASE=8, one with defaults.
module tb_param_expr_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       va = 1'b0, vb = 1'b0, ora = 1'b1, orb = 1'b1;
  logic [7:0] ya = '0, yb = '0;
  logic       ra, rb, ova, ovb;
  logic [7:0] xa, xb, rma, rmb;
  logic       ufa, ufb, exa, exb, ira, irb;

  param_expr_decoder #(.WIDTH(8), .BASE(8), .MULTIPLIER(3), .OFFSET(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_y(ya),
    .out_valid(ova), .out_ready(ora), .out_x(xa), .out_rem(rma),
    .out_underflow(ufa), .out_exact(exa), .out_is_result(ira));

  param_expr_decoder dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_y(yb),
    .out_valid(ovb), .out_ready(orb), .out_x(xb), .out_rem(rmb),
    .out_underflow(ufb), .out_exact(exb), .out_is_result(irb));

  typedef struct {
    logic [7:0] x, rem;
    logic       uf, ex, isr;
    int         lat;
  } res_t;

  typedef struct {
    logic [7:0] y, x, rem;
    logic       uf, ex, isr;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Present y to decoder a (sel=0) or b (sel=1) and wait for its result.
  task automatic op(input bit sel, input logic [7:0] y, output res_t r);
    int n;
    @(negedge clk);
    if (sel) begin vb = 1'b1; yb = y; end else begin va = 1'b1; ya = y; end
    n = 0;
    while (!(sel ? rb : ra) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    va = 1'b0; vb = 1'b0; ya = 8'h5a; yb = 8'h5a;
    r.lat = 0;
    while (!(sel ? ovb : ova) && r.lat < 50) begin @(posedge clk); #1; r.lat++; end
    r.x   = sel ? xb  : xa;
    r.rem = sel ? rmb : rma;
    r.uf  = sel ? ufb : ufa;
    r.ex  = sel ? exb : exa;
    r.isr = sel ? irb : ira;
  endtask

  task automatic chk_res(input string tag, input res_t r, input vec_t v);
    chk({tag, ".lat"}, r.lat, 10);
    chk({tag, ".x"},   r.x,   v.x);
    chk({tag, ".rem"}, r.rem, v.rem);
    chk({tag, ".uf"},  r.uf,  v.uf);
    chk({tag, ".ex"},  r.ex,  v.ex);
    chk({tag, ".isr"}, r.isr, v.isr);
  endtask

  vec_t vt[8];
  res_t r, held;
  vec_t v;

  initial begin
    vt[0] = '{8'd29,  8'd8,  8'd0, 1'b0, 1'b1, 1'b1};
    vt[1] = '{8'd30,  8'd8,  8'd1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'd255, 8'd83, 8'd1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'd4,   8'd0,  8'd0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{8'd5,   8'd0,  8'd0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'd11,  8'd2,  8'd0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'd0,   8'd0,  8'd0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'd7,   8'd0,  8'd2, 1'b0, 1'b0, 1'b0};

    // in_valid asserted during reset must not start an operation
    va = 1'b1; ya = 8'd29;
    repeat (2) @(posedge clk);
    #1;
    va = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready", ra, 1);
    chk("rst.out_valid", ova, 0);
    chk("rst.out_x", xa, 0);
    chk("rst.out_rem", rma, 0);
    chk("rst.flags", {ufa, exa, ira}, 0);

    for (int i = 0; i < 8; i++) begin
      op(1'b0, vt[i].y, r);
      chk_res($sformatf("vec%0d", i), r, vt[i]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.post_valid", i), ova, 0);
      chk($sformatf("vec%0d.post_ready", i), ra, 1);
    end

    // back-pressure: result held for 20 cycles, new input offered but ignored
    ora = 1'b0;
    op(1'b0, 8'd30, held);
    chk_res("bp", held, vt[1]);
    ya = 8'd200; va = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!ova || !(xa == held.x && rma == held.rem && ufa == held.uf && exa == held.ex)
          || ra) begin
        chk($sformatf("bp.stable%0d", i), {ova, ra, xa, rma}, {1'b1, 1'b0, held.x, held.rem});
      end else n_cmp++;
    end
    va = 1'b0;
    ora = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", ova, 0);
    chk("bp.release_ready", ra, 1);

    // reset mid-operation
    @(negedge clk);
    va = 1'b1; ya = 8'd29;
    @(posedge clk); #1;
    va = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.in_ready", ra, 1);
    chk("midrst.out_valid", ova, 0);
    begin
      int seen = 0;
      repeat (12) begin @(posedge clk); #1; if (ova) seen++; end
      chk("midrst.no_stale", seen, 0);
    end
    op(1'b0, 8'd11, r);
    chk_res("midrst.next", r, vt[5]);
    @(posedge clk); #1;

    // default configuration: RESULT = 25
    op(1'b1, 8'd25, r);
    chk_res("def25", r, '{8'd25, 8'd10, 8'd0, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] y;
      int d;
      y = (i < 3) ? ((i == 0) ? 8'd4 : (i == 1) ? 8'd5 : 8'd255) : 8'($urandom_range(0, 255));
      d = int'(y) - 5;
      v.y = y;
      v.uf = (d < 0);
      v.x = v.uf ? 8'd0 : 8'(d / 2);
      v.rem = v.uf ? 8'd0 : 8'(d % 2);
      v.ex = !v.uf && (v.rem == 0);
      v.isr = (y == 8'd25);
      op(1'b1, y, r);
      chk_res($sformatf("sweep_y%0d", y), r, v);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
